// File: rtl/clock_display.sv
// Multiplexed HH.MM.SS driver for a 6-digit common-anode 7-segment display.
// Binary time fields are converted to BCD once per frame by a subtract-by-10 engine.
module clock_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic       CLK50M,
  input  logic       RST,
  input  logic [4:0] hours,
  input  logic [7:0] minutes,
  input  logic [7:0] seconds,
  output logic [6:0] seg,
  output logic       dp,
  output logic [5:0] an,
  output logic       busy
);

  localparam int unsigned CW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam logic [3:0] DASH = 4'hA;

  typedef enum logic [2:0] {
    IDLE, CHK_H, SUB_H, CHK_M, SUB_M, CHK_S, SUB_S, COMMIT
  } state_t;

  function automatic logic [6:0] seg_enc(input logic [3:0] d);
    case (d)
      4'd0:    seg_enc = 7'h40;
      4'd1:    seg_enc = 7'h79;
      4'd2:    seg_enc = 7'h24;
      4'd3:    seg_enc = 7'h30;
      4'd4:    seg_enc = 7'h19;
      4'd5:    seg_enc = 7'h12;
      4'd6:    seg_enc = 7'h02;
      4'd7:    seg_enc = 7'h78;
      4'd8:    seg_enc = 7'h00;
      4'd9:    seg_enc = 7'h10;
      DASH:    seg_enc = 7'h3F;
      default: seg_enc = 7'h7F;
    endcase
  endfunction

  logic [CW-1:0] scan_cnt_q;
  logic [2:0]    idx_q;
  logic [5:0]    an_q;
  logic [6:0]    seg_q;
  logic          dp_q;

  state_t        state_q;
  logic          busy_q;
  logic          pend_q;
  logic [4:0]    h_snap_q;
  logic [7:0]    m_snap_q;
  logic [7:0]    s_snap_q;
  logic [7:0]    rem_q;
  logic [3:0]    tens_q;
  logic [3:0]    wk_q   [6];
  logic [3:0]    disp_q [6];

  logic          scan_wrap_s;
  logic          trig_s;
  logic [3:0]    cur_digit_s;
  logic [7:0]    fld_val_s;
  logic [7:0]    fld_lim_s;
  logic [2:0]    fld_hi_s;
  logic [2:0]    fld_lo_s;
  state_t        fld_sub_s;
  state_t        fld_next_s;

  assign scan_wrap_s = (scan_cnt_q == CW'(SCAN_DIV - 1));
  assign trig_s      = pend_q | (scan_wrap_s & (idx_q == 3'd5));

  always_comb begin
    case (idx_q)
      3'd0:    cur_digit_s = disp_q[0];
      3'd1:    cur_digit_s = disp_q[1];
      3'd2:    cur_digit_s = disp_q[2];
      3'd3:    cur_digit_s = disp_q[3];
      3'd4:    cur_digit_s = disp_q[4];
      3'd5:    cur_digit_s = disp_q[5];
      default: cur_digit_s = 4'hF;
    endcase
  end

  // Field currently being converted: source, range limit and digit slots.
  always_comb begin
    case (state_q)
      CHK_H, SUB_H: begin
        fld_val_s = {3'd0, h_snap_q}; fld_lim_s = 8'd23;
        fld_hi_s = 3'd5; fld_lo_s = 3'd4; fld_sub_s = SUB_H; fld_next_s = CHK_M;
      end
      CHK_M, SUB_M: begin
        fld_val_s = m_snap_q; fld_lim_s = 8'd59;
        fld_hi_s = 3'd3; fld_lo_s = 3'd2; fld_sub_s = SUB_M; fld_next_s = CHK_S;
      end
      CHK_S, SUB_S: begin
        fld_val_s = s_snap_q; fld_lim_s = 8'd59;
        fld_hi_s = 3'd1; fld_lo_s = 3'd0; fld_sub_s = SUB_S; fld_next_s = COMMIT;
      end
      default: begin
        fld_val_s = 8'd0; fld_lim_s = 8'd0;
        fld_hi_s = 3'd0; fld_lo_s = 3'd0; fld_sub_s = IDLE; fld_next_s = IDLE;
      end
    endcase
  end

  // Digit scan timing and registered display pins.
  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      scan_cnt_q <= '0;
      idx_q      <= 3'd0;
      an_q       <= 6'h3F;
      seg_q      <= 7'h7F;
      dp_q       <= 1'b1;
    end else begin
      if (scan_wrap_s) begin
        scan_cnt_q <= '0;
        idx_q      <= (idx_q == 3'd5) ? 3'd0 : idx_q + 3'd1;
      end else begin
        scan_cnt_q <= scan_cnt_q + CW'(1);
      end
      an_q  <= ~(6'b00_0001 << idx_q);
      seg_q <= seg_enc(cur_digit_s);
      dp_q  <= ~((idx_q == 3'd2) || (idx_q == 3'd4));
    end
  end

  // BCD conversion engine; the last subtraction also resolves the ones digit.
  always_ff @(posedge CLK50M or posedge RST) begin
    if (RST) begin
      state_q  <= IDLE;
      busy_q   <= 1'b0;
      pend_q   <= 1'b1;
      h_snap_q <= 5'd0;
      m_snap_q <= 8'd0;
      s_snap_q <= 8'd0;
      rem_q    <= 8'd0;
      tens_q   <= 4'd0;
      for (int i = 0; i < 6; i++) begin
        wk_q[i]   <= 4'd0;
        disp_q[i] <= 4'd0;
      end
    end else begin
      pend_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (trig_s) begin
            h_snap_q <= hours;
            m_snap_q <= minutes;
            s_snap_q <= seconds;
            busy_q   <= 1'b1;
            state_q  <= CHK_H;
          end else begin
            busy_q   <= 1'b0;
          end
        end
        CHK_H, CHK_M, CHK_S: begin
          if (fld_val_s > fld_lim_s) begin
            wk_q[fld_hi_s] <= DASH;
            wk_q[fld_lo_s] <= DASH;
            state_q        <= fld_next_s;
          end else begin
            tens_q  <= 4'd0;
            rem_q   <= fld_val_s;
            state_q <= fld_sub_s;
          end
        end
        SUB_H, SUB_M, SUB_S: begin
          if (rem_q >= 8'd10) begin
            rem_q  <= rem_q - 8'd10;
            tens_q <= tens_q + 4'd1;
            if (rem_q < 8'd20) begin
              wk_q[fld_hi_s] <= tens_q + 4'd1;
              wk_q[fld_lo_s] <= rem_q[3:0] - 4'd10;
              state_q        <= fld_next_s;
            end else begin
              state_q        <= state_q;
            end
          end else begin
            wk_q[fld_hi_s] <= tens_q;
            wk_q[fld_lo_s] <= rem_q[3:0];
            state_q        <= fld_next_s;
          end
        end
        COMMIT: begin
          for (int i = 0; i < 6; i++) begin
            disp_q[i] <= wk_q[i];
          end
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: begin
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign seg  = seg_q;
  assign dp   = dp_q;
  assign an   = an_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_clock_display.sv
// Directed bench for clock_display with SCAN_DIV = 4 (24-cycle frames).
module tb_clock_display;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [4:0] h   = 5'd0;
  logic [7:0] m   = 8'd0;
  logic [7:0] s   = 8'd0;
  logic [6:0] seg;
  logic       dp;
  logic [5:0] an;
  logic       busy;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct packed {
    logic [4:0]      h;
    logic [7:0]      m;
    logic [7:0]      s;
    logic [5:0][6:0] seg;   // [5] = hours tens ... [0] = seconds ones
  } vec_t;

  vec_t vecs [8];

  clock_display #(.SCAN_DIV(4)) dut (
    .CLK50M(clk), .RST(rst), .hours(h), .minutes(m), .seconds(s),
    .seg(seg), .dp(dp), .an(an), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_vec++;
    n_bad++;
    $display("FAIL %s: timed out, got no event, expected one", name);
  endtask

  // Returns at the first negedge where an has just become 6'h3E.
  task automatic wait_frame_start();
    int k = 0;
    while (an == 6'h3E && k < 200) begin @(negedge clk); k++; end
    while (an != 6'h3E && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) timeout("frame_start");
  endtask

  task automatic wait_busy(input logic lvl, input string name);
    int k = 0;
    while (busy !== lvl && k < 200) begin @(negedge clk); k++; end
    if (k >= 200) timeout(name);
  endtask

  // Counts negedge samples with busy high, starting at a sample where busy is high.
  task automatic busy_len(output int len);
    len = 0;
    while (busy === 1'b1 && len < 100) begin len++; @(negedge clk); end
  endtask

  task automatic capture(input string name, input logic [5:0][6:0] exp);
    logic [6:0] sg [6];
    logic an_ok = 1'b1, dp_ok = 1'b1, stable = 1'b1;
    wait_frame_start();
    for (int d = 0; d < 6; d++) begin
      for (int c = 0; c < 4; c++) begin
        if (c == 0) sg[d] = seg;
        else if (seg !== sg[d]) stable = 1'b0;
        if (an !== ~(6'b00_0001 << d)) an_ok = 1'b0;
        if (dp !== ((d == 2 || d == 4) ? 1'b0 : 1'b1)) dp_ok = 1'b0;
        @(negedge clk);
      end
    end
    for (int d = 0; d < 6; d++) check($sformatf("%s_seg_an%0d", name, d), 32'(sg[d]), 32'(exp[d]));
    check({name, "_an_seq"}, 32'(an_ok), 32'd1);
    check({name, "_dp"}, 32'(dp_ok), 32'd1);
    check({name, "_seg_steady"}, 32'(stable), 32'd1);
  endtask

  initial begin
    int len;
    int bl_s   [4] = '{0, 9, 10, 59};
    int bl_exp [4] = '{7, 7, 7, 11};

    vecs[0] = {5'd0,  8'd0,  8'd0,  7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40};
    vecs[1] = {5'd23, 8'd59, 8'd58, 7'h24, 7'h30, 7'h12, 7'h10, 7'h12, 7'h00};
    vecs[2] = {5'd24, 8'd60, 8'd7,  7'h3F, 7'h3F, 7'h3F, 7'h3F, 7'h40, 7'h78};
    vecs[3] = {5'd5,  8'd0,  8'd9,  7'h40, 7'h12, 7'h40, 7'h40, 7'h40, 7'h10};
    vecs[4] = {5'd0,  8'd0,  8'd10, 7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40};
    vecs[5] = {5'd12, 8'd34, 8'd59, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h10};
    vecs[6] = {5'd31, 8'd45, 8'd60, 7'h3F, 7'h3F, 7'h19, 7'h12, 7'h3F, 7'h3F};
    vecs[7] = {5'd18, 8'd7,  8'd36, 7'h79, 7'h00, 7'h40, 7'h78, 7'h30, 7'h02};

    // Reset state and first conversion after release.
    repeat (3) @(negedge clk);
    check("rst_seg", 32'(seg), 32'h7F);
    check("rst_an", 32'(an), 32'h3F);
    check("rst_dp", 32'(dp), 32'd1);
    check("rst_busy", 32'(busy), 32'd0);
    rst = 1'b0;
    @(negedge clk);
    check("boot_an", 32'(an), 32'h3E);
    check("boot_busy", 32'(busy), 32'd1);
    busy_len(len);
    check("boot_busy_len", 32'(len), 32'd7);
    capture("boot", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    // Table of steady inputs, each checked on a clean frame.
    for (int i = 0; i < 8; i++) begin
      h = vecs[i].h; m = vecs[i].m; s = vecs[i].s;
      wait_frame_start();
      wait_frame_start();
      capture($sformatf("vec%0d", i), vecs[i].seg);
    end

    // Busy pulse length tracks the seconds subtract count.
    for (int i = 0; i < 4; i++) begin
      wait_busy(1'b0, "bl_idle");
      h = 5'd0; m = 8'd0; s = 8'(bl_s[i]);
      wait_busy(1'b1, "bl_rise");
      busy_len(len);
      check($sformatf("busy_len_s%0d", bl_s[i]), 32'(len), 32'(bl_exp[i]));
    end

    // Inputs changed after the snapshot leave the running conversion alone.
    wait_busy(1'b0, "snap_idle");
    h = 5'd0; m = 8'd59; s = 8'd0;
    wait_busy(1'b1, "snap_rise");
    m = 8'd0;
    len = 0;
    while (an != 6'h37 && len < 100) begin @(negedge clk); len++; end
    if (len >= 100) timeout("snap_an3");
    check("snap_min_tens", 32'(seg), 32'h12);
    wait_frame_start();
    capture("snap_after", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h40});

    // Seconds 9 -> 10 mid-frame: no effect until the next frame commit.
    h = 5'd0; m = 8'd0; s = 8'd9;
    wait_frame_start();
    wait_frame_start();
    capture("mid_old", {7'h40, 7'h40, 7'h40, 7'h40, 7'h40, 7'h10});
    len = 0;
    while (an != 6'h37 && len < 100) begin @(negedge clk); len++; end
    if (len >= 100) timeout("mid_an3");
    s = 8'd10;
    len = 0;
    while (an != 6'h1F && len < 100) begin
      if (busy !== 1'b0) len = 1000;
      @(negedge clk);
      len++;
    end
    check("mid_no_early_conv", 32'(len < 100), 32'd1);
    wait_frame_start();
    check("mid_ones_held", 32'(seg), 32'h10);
    capture("mid_new", {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h40});

    // Reset during minutes subtraction.
    wait_busy(1'b0, "rsub_idle");
    h = 5'd0; m = 8'd59; s = 8'd0;
    wait_busy(1'b1, "rsub_rise");
    repeat (3) @(negedge clk);
    check("rsub_busy_before", 32'(busy), 32'd1);
    rst = 1'b1;
    #1;
    check("rsub_an", 32'(an), 32'h3F);
    check("rsub_busy", 32'(busy), 32'd0);
    check("rsub_seg", 32'(seg), 32'h7F);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    busy_len(len);
    check("rsub_busy_len", 32'(len), 32'd11);
    capture("rsub_after", {7'h40, 7'h40, 7'h12, 7'h10, 7'h40, 7'h40});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/clock_display.md
Name: clock_display

Overview:
- Downstream consumer of the time-of-day counter block.
- Takes binary hours/minutes/seconds and converts each field to two BCD digits with a small sequential subtract-by-10 engine.
- Drives a 6-digit, common-anode, multiplexed 7-segment display in HH.MM.SS format.
- Sits between the time counter and the board display pins.

Parameters:
- SCAN_DIV, 50000: CLK50M cycles each digit stays enabled. Legal range is 32 or more. Set to 4 in simulation.

Ports:
- CLK50M  input  1  system clock; all state changes on its rising edge.
- RST  input  1  asynchronous, active-high reset.
- hours  input  5  binary hours; valid range 0..23.
- minutes  input  8  binary minutes; valid range 0..59.
- seconds  input  8  binary seconds; valid range 0..59.
- seg  output  7  segment drive, active-low, bit order {g,f,e,d,c,b,a}.
- dp  output  1  decimal point, active-low.
- an  output  6  digit anode enables, active-low, one-hot.
  - an[5] = hours tens, an[4] = hours ones, an[3] = minutes tens, an[2] = minutes ones, an[1] = seconds tens, an[0] = seconds ones.
- busy  output  1  high while the BCD conversion engine is running.

Behaviour:
- Reset, asserted asynchronously:
  - seg = 7'h7F, dp = 1, an = 6'h3F (all digits off), busy = 0.
  - Scan counter = 0, digit index = 0, all six BCD display registers = 0, FSM = IDLE.
  - A conversion is pending, to be triggered on the first clock after release.
- Scan:
  - scan_cnt counts 0..SCAN_DIV-1.
  - When scan_cnt = SCAN_DIV-1, it wraps to 0 and the digit index advances 0→1→…→5→0.
  - an, seg and dp are registered and reflect the current index one cycle later.
  - Exactly one an bit is low at any time after the first post-reset cycle.
- dp is 0 only while an[4] or an[2] is active, marking the separators after HH and after MM; otherwise dp = 1.
- Conversion trigger:
  - Fires in the cycle after reset release.
  - Fires again each time the digit index wraps 5→0, i.e. once per frame of 6*SCAN_DIV cycles.
- On trigger, snapshot hours/minutes/seconds into internal registers. Input changes after the snapshot do not affect the conversion in progress.
- FSM states:
  - IDLE → CHK_H on trigger, busy = 1.
  - CHK_H: if hours > 23, mark the field invalid and go to CHK_M. Otherwise go to SUB_H with tens = 0, rem = hours.
  - SUB_H: while rem ≥ 10, do rem -= 10 and tens += 1, one subtraction per cycle. When rem < 10, ones = rem and go to CHK_M.
  - CHK_M / SUB_M and CHK_S / SUB_S are identical, with limit 59, using minutes and seconds.
  - After SUB_S or an invalid CHK_S, go to COMMIT.
  - COMMIT: load all six display digit registers in one cycle (no partial-frame tearing), busy = 0, then IDLE.
- Worst-case latency from trigger to COMMIT is 3 check cycles + (2+5+5) subtract cycles + 1 commit cycle, which is ≤ 16 cycles. This is always shorter than one digit period.
- A trigger arriving while busy is impossible by construction (SCAN_DIV ≥ 32). If it occurs anyway, it is ignored.
- Segment encoding, active-low (blank = 7'h7F):
  - 0 = 7'h40, 1 = 7'h79, 2 = 7'h24, 3 = 7'h30, 4 = 7'h19.
  - 5 = 7'h12, 6 = 7'h02, 7 = 7'h78, 8 = 7'h00, 9 = 7'h10.
  - Dash = 7'h3F.
- An invalid field shows dash on both of its digits. Other fields are unaffected.
- No leading-zero blanking: hour 5 displays "05".
- Reset asserted mid-conversion or mid-scan:
  - All outputs return immediately to reset values.
  - The in-flight conversion is discarded.
  - A fresh trigger follows release.

Test Plan (SCAN_DIV=4):
- Reset release with h=0, m=0, s=0:
  - seg = 7'h7F, an = 6'h3F while RST = 1.
  - Within 16 cycles busy falls.
  - The an sequence is 3E,3D,3B,37,2F,1F, each lasting 4 cycles, with seg = 7'h40 on every digit.
- h=23, m=59, s=58:
  - Digits read 2,3,5,9,5,8 → seg 24,30,12,10,12,00 on an[5..0].
  - dp = 0 only on an[4] and an[2].
- h=24, m=60, s=7: all four H/M digits show 7'h3F; seconds show 0,7 (7'h40, 7'h78).
- Change s from 9 to 10 mid-frame:
  - The display keeps 0,9 until the next 5→0 wrap.
  - After that COMMIT it shows 1,0.
  - No frame ever mixes old and new digits.
- Assert RST during SUB_M:
  - an = 6'h3F and busy = 0 at once.
  - After release, a correct full conversion of the current inputs completes.
- Boundary values s=0, 9, 10, 59:
  - Tens/ones are 0/0, 0/9, 1/0 and 5/9.
  - busy pulse lengths differ according to the subtract count.
